sync_param_fifo: RTL
====================

Name: sync_param_fifo

Overview:
Parametrised successor of the channel slave FIFO. It buffers write-side data words for an arbiter/formatter that drains them.
- Width and depth are configurable.
- Writes when full and reads when empty are protected; neither corrupts pointers or the free-slot count.
- Sticky overflow and underflow flags, plus a synchronous flush.
- First-word-fall-through read data.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 5, pointer width; depth DEPTH = 2**ADDR_W (derived localparam, not overridable)
AFULL_TH, 4, almost_full_o asserts when freeslot_o <= AFULL_TH (used only with watermark feature)
AEMPTY_TH, 4, almost_empty_o asserts when (DEPTH - freeslot_o) <= AEMPTY_TH (used only with watermark feature)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
clr_i  in  1  synchronous flush; pointers reset, flags cleared
wr_i  in  1  write request
data_i  in  DATA_W  write data
rd_i  in  1  read request (pop)
data_o  out  DATA_W  head-of-FIFO word, combinational from storage
full_o  out  1  freeslot_o == 0
empty_o  out  1  freeslot_o == DEPTH
overflow_o  out  1  sticky: a write was attempted while full and not accepted
underflow_o  out  1  sticky: a read was attempted while empty and not accepted
freeslot_o  out  ADDR_W+1  free entries, 0..DEPTH
almost_full_o  out  1  watermark, present only with SYNC_PARAM_FIFO_WMARK_EN
almost_empty_o  out  1  watermark, present only with SYNC_PARAM_FIFO_WMARK_EN

Behaviour:
- One clock; reset is asynchronous and active-low (clk_i, rst_n_i).
- Reset: wr_p = rd_p = 0, freeslot_o = DEPTH, empty_o = 1, full_o = 0, overflow_o = 0, underflow_o = 0. Storage contents are not reset, so data_o is undefined while empty.
- Acceptance rules:
  - wr_acc = wr_i & (~full | rd_acc)
  - rd_acc = rd_i & ~empty
- A write while full is accepted only when paired with an accepted read.
- Accepted write: mem[wr_p] <= data_i; wr_p <= wr_p + 1. Pointer wraps modulo DEPTH naturally.
- Accepted read: rd_p <= rd_p + 1, with the same wrap.
- data_o = mem[rd_p]; the next word is visible the cycle after the pop.
- Free-slot count:
  - wr_acc & ~rd_acc: freeslot -1
  - rd_acc & ~wr_acc: freeslot +1
  - both or neither: unchanged
- Error flags:
  - wr_i & ~wr_acc sets overflow_o.
  - rd_i & ~rd_acc sets underflow_o. This includes rd+wr on an empty FIFO: the write is accepted, the read is rejected, underflow_o sets, freeslot_o becomes DEPTH-1.
  - Both flags hold until clr_i or reset.
- clr_i has priority over wr_i and rd_i in the same cycle. It restores the reset values above (storage untouched); the requests in that cycle are discarded and do not set flags.
- Latency: a word written in cycle N appears on data_o and empty_o deasserts after edge N+1.
- Asserting rst_n_i mid-transfer empties the FIFO immediately (asynchronous), with no partial update.

Optional Feature:
Macro SYNC_PARAM_FIFO_WMARK_EN.
- Defined: almost_full_o and almost_empty_o ports exist.
  - Both are combinational compares on freeslot_o per AFULL_TH / AEMPTY_TH.
  - Reset values: almost_full_o = 0 (if AFULL_TH < DEPTH), almost_empty_o = 1.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package/header mcdf_fifo_pkg holds:
  - default DATA_W and ADDR_W
  - the DEPTH derivation function
  - freeslot width constant ADDR_W+1
- One sub-module, sync_param_fifo_ram: DEPTH x DATA_W array, one synchronous write port, one asynchronous read port, no reset.
- Control, pointers, count and flags stay in sync_param_fifo.

Test Plan:
- Reset then 32 writes 0x0..0x1F (defaults): freeslot_o counts 32 down to 0, full_o = 1 after the 32nd edge, overflow_o = 0.
- From full, 33rd write 0xDEAD: write ignored, overflow_o = 1 sticky, freeslot_o = 0; 32 reads return 0x0..0x1F in order, empty_o = 1.
- Empty, rd_i = 1 with wr_i = 1, data 0xA5: underflow_o = 1, freeslot_o = 31, data_o = 0xA5 next cycle.
- Full, simultaneous rd_i and wr_i of 0x55 for 40 cycles: full_o stays 1, no overflow, pointers wrap, output order preserved.
- 10 words loaded with overflow_o set, then clr_i pulsed together with wr_i: freeslot_o = 32, empty_o = 1, overflow_o = 0, the write is discarded.
- WMARK_EN defined, AFULL_TH = 4, AEMPTY_TH = 4: almost_empty_o drops on the 5th write, almost_full_o rises on the 28th write.

Source files
------------

// File: rtl/mcdf_fifo_pkg.sv
// mcdf_fifo_pkg: shared defaults and size helpers for the sync_param_fifo family
package mcdf_fifo_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_FS_W = DEF_ADDR_W + 1;
  function automatic int depth_f(input int aw);
    return 1 << aw;
  endfunction
  function automatic int fs_w_f(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/sync_param_fifo_ram.sv
// sync_param_fifo_ram: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset
module sync_param_fifo_ram
  import mcdf_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [depth_f(ADDR_W)];
  always_ff @(posedge clk_i) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_param_fifo.sv
// sync_param_fifo: FWFT synchronous FIFO with sticky overflow/underflow and flush.
// Watermark outputs almost_full_o/almost_empty_o exist only with SYNC_PARAM_FIFO_WMARK_EN.
module sync_param_fifo
  import mcdf_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_TH  = 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  output logic              underflow_o,
`ifdef SYNC_PARAM_FIFO_WMARK_EN
  output logic              almost_full_o,
  output logic              almost_empty_o,
`endif
  output logic [ADDR_W:0]   freeslot_o
);
  localparam int DEPTH = depth_f(ADDR_W);
  localparam int FS_W = fs_w_f(ADDR_W);
  logic [ADDR_W-1:0] wr_p, rd_p;
  logic rd_acc, wr_acc;
  logic [FS_W-1:0] fs_nxt;
  assign full_o  = freeslot_o == '0;
  assign empty_o = freeslot_o == FS_W'(DEPTH);
  assign rd_acc  = rd_i & ~empty_o;
  assign wr_acc  = wr_i & (~full_o | rd_acc);
  always_comb begin
    fs_nxt = (wr_acc & ~rd_acc) ? freeslot_o - FS_W'(1) :
             (rd_acc & ~wr_acc) ? freeslot_o + FS_W'(1) : freeslot_o;
  end
  // flush wins over same-cycle requests, which then neither move pointers nor set flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_p        <= '0;
      rd_p        <= '0;
      freeslot_o  <= FS_W'(DEPTH);
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_p        <= '0;
      rd_p        <= '0;
      freeslot_o  <= FS_W'(DEPTH);
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      wr_p        <= wr_acc ? wr_p + ADDR_W'(1) : wr_p;
      rd_p        <= rd_acc ? rd_p + ADDR_W'(1) : rd_p;
      freeslot_o  <= fs_nxt;
      overflow_o  <= overflow_o | (wr_i & ~wr_acc);
      underflow_o <= underflow_o | (rd_i & ~rd_acc);
    end
  end
  sync_param_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_i(clk_i),
    .we   (wr_acc & ~clr_i),
    .waddr(wr_p),
    .wdata(data_i),
    .raddr(rd_p),
    .rdata(data_o)
  );
`ifdef SYNC_PARAM_FIFO_WMARK_EN
  assign almost_full_o  = freeslot_o <= FS_W'(AFULL_TH);
  assign almost_empty_o = (FS_W'(DEPTH) - freeslot_o) <= FS_W'(AEMPTY_TH);
`endif
endmodule
